// File: rtl/rle_pkg.sv
// Shared types and sizing helpers for the run-length bit unpacker.
package rle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    localparam int OUT_W_DFLT = 8;
    localparam int FILL_W     = $clog2(OUT_W_DFLT) + 1;

    function automatic int fill_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/rle_out_slot.sv
// Single-entry valid/ready holding register for decoded words.
module rle_out_slot
    import rle_pkg::*;
#(
    parameter int DATA_W = OUT_W_DFLT,
    parameter int NB_W   = FILL_W,
    parameter int IDX_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [NB_W-1:0]   ld_nbits,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic              ld_last,
    input  logic              ready,
    output logic              free,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [NB_W-1:0]   nbits,
    output logic [IDX_W-1:0]  idx,
    output logic              last
);

    // A load in the handshake cycle replaces the word with no bubble.
    assign free = !valid || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            nbits <= '0;
            idx   <= '0;
            last  <= 1'b0;
        end else if (clr) begin
            valid <= 1'b0;
            data  <= '0;
            nbits <= '0;
            idx   <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= ld_data;
            nbits <= ld_nbits;
            idx   <= ld_idx;
            last  <= ld_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rle_stream_unpacker.sv
// Run-length token expander: one bit per cycle into MSB-first words.
module rle_stream_unpacker
    import rle_pkg::*;
#(
    parameter int RUN_W = 3,
    parameter int OUT_W = 8,
    parameter int IDX_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   work,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_bit,
    input  logic [RUN_W-1:0]       in_len,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [$clog2(OUT_W):0] out_nbits,
    output logic [IDX_W-1:0]       out_byte_idx,
    output logic                   out_last,
    output logic [$clog2(OUT_W):0] bit_idx,
    output logic                   done
);

    localparam int FW = fill_w(OUT_W);
    localparam int AW = $clog2(OUT_W);

    state_t           state_q, state_d;
    logic [RUN_W-1:0] rem_q, rem_d;
    logic             val_q, val_d;
    logic             lp_q, lp_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [OUT_W-1:0] asm_q, asm_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    logic             ld, clr, free;
    logic [OUT_W-1:0] ld_data;
    logic [FW-1:0]    ld_nbits;
    logic             ld_last;
    logic             last_bit, full;
    logic [AW-1:0]    pos;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            val_q   <= 1'b0;
            lp_q    <= 1'b0;
            fill_q  <= '0;
            asm_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            val_q   <= val_d;
            lp_q    <= lp_d;
            fill_q  <= fill_d;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        val_d    = val_q;
        lp_d     = lp_q;
        fill_d   = fill_q;
        asm_d    = asm_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        ld       = 1'b0;
        clr      = 1'b0;
        ld_data  = asm_q;
        ld_nbits = fill_q;
        ld_last  = 1'b0;
        last_bit = lp_q && (rem_q == RUN_W'(1));
        full     = (fill_q == FW'(OUT_W - 1));
        pos      = AW'(OUT_W - 1 - int'(fill_q));

        unique case (state_q)
            IDLE: begin
                if (work) state_d = RUN;
            end
            RUN: begin
                if (rem_q != '0) begin
                    if (!full) begin
                        asm_d[pos] = val_q;
                        fill_d     = fill_q + FW'(1);
                        rem_d      = rem_q - RUN_W'(1);
                    end else if (free) begin
                        // Final bit goes straight into the word.
                        ld       = 1'b1;
                        ld_data  = {asm_q[OUT_W-1:1], val_q};
                        ld_nbits = FW'(OUT_W);
                        ld_last  = last_bit;
                        asm_d    = '0;
                        fill_d   = '0;
                        cnt_d    = cnt_q + IDX_W'(1);
                        rem_d    = rem_q - RUN_W'(1);
                        if (last_bit) state_d = DONE;
                    end
                end else if (lp_q) begin
                    state_d = FLUSH;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        rem_d = in_len;
                        val_d = in_bit;
                        lp_d  = in_last;
                    end
                end
            end
            FLUSH: begin
                if (free) begin
                    ld      = 1'b1;
                    ld_last = 1'b1;
                    asm_d   = '0;
                    fill_d  = '0;
                    cnt_d   = cnt_q + IDX_W'(1);
                    state_d = DONE;
                end
            end
            DONE: begin
            end
        endcase

        // Dropping work discards everything in flight.
        if (state_q != IDLE && !work) begin
            state_d  = IDLE;
            clr      = 1'b1;
            ld       = 1'b0;
            in_ready = 1'b0;
            rem_d    = '0;
            val_d    = 1'b0;
            lp_d     = 1'b0;
            fill_d   = '0;
            asm_d    = '0;
            cnt_d    = '0;
        end
    end

    rle_out_slot #(
        .DATA_W (OUT_W),
        .NB_W   (FW),
        .IDX_W  (IDX_W)
    ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (ld),
        .ld_data  (ld_data),
        .ld_nbits (ld_nbits),
        .ld_idx   (cnt_q),
        .ld_last  (ld_last),
        .ready    (out_ready),
        .free     (free),
        .valid    (out_valid),
        .data     (out_data),
        .nbits    (out_nbits),
        .idx      (out_byte_idx),
        .last     (out_last)
    );

    assign bit_idx = fill_q;
    assign done    = (state_q == DONE);

endmodule
